// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 set-2 key decoder.
package ps2_pkg;

    // Frame receiver states: start bit seen in IDLE, 8 data bits, parity, stop.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    // Set-2 prefix bytes.
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Number of bytes following E1 that belong to the Pause sequence.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Event word handed to the keyboard matrix.
    typedef struct packed {
        logic       tgl;
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } ps2_key_t;

    // Keyboard status/handshake replies that never describe a key.
    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: hit = 1'b1;
            default:                                  hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Odd parity over data byte plus parity bit.
    function automatic logic parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame
// FSM and inactivity timeout. Produces one byte per valid frame.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       timeout_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_s;
    logic          data_s;

    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe_s;

    frame_state_e  state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          tout_q, tout_d;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Two-flop synchronizers; idle-high pins reset to 1 so no false edge appears.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // Glitch filter: level flips only after FILTER_LEN samples of the new level; a flip to 0 is the bit strobe.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        strobe_s   = 1'b0;
        if (clk_s != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_clk_d = clk_s;
                filt_cnt_d = '0;
                strobe_s   = ~clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    // Frame FSM next state, timeout counter and one-cycle result pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        tout_d  = 1'b0;

        if ((state_q == ST_IDLE) || strobe_s) begin
            to_d = '0;
        end else begin
            to_d = to_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe_s) begin
                    if (data_s == 1'b0) begin
                        state_d = ST_DATA;
                        cnt_d   = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (strobe_s) begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (strobe_s) begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (strobe_s) begin
                    state_d = ST_IDLE;
                    if (data_s && parity_ok(shift_q, par_q)) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled partial frame is abandoned; a strobe in the same cycle takes priority.
        if ((state_q != ST_IDLE) && !strobe_s && (to_q == TO_LIMIT)) begin
            state_d = ST_IDLE;
            to_d    = '0;
            err_d   = 1'b1;
            tout_d  = 1'b1;
        end else begin
            tout_d = 1'b0;
        end
    end

    // Filter, FSM and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            to_q       <= '0;
            byte_q     <= 8'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_q       <= to_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            tout_q     <= tout_d;
        end
    end

    assign rx_byte_o    = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;
    assign timeout_o    = tout_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: turns set-2 byte streams into the 11-bit
// {toggle, pressed, ext, code} event word used by the keyboard matrix.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);

    logic [7:0] rx_byte_s;
    logic       byte_valid_s;
    logic       frame_err_s;
    logic       timeout_s;

    ps2_key_t   key_q, key_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       err_q, err_d;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i        (clk),
        .reset_i      (reset),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .rx_byte_o    (rx_byte_s),
        .byte_valid_o (byte_valid_s),
        .frame_err_o  (frame_err_s),
        .timeout_o    (timeout_s)
    );

    // Prefix layer: track E0/F0 state and the Pause skip count, emit an event for plain codes.
    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        err_d  = frame_err_s;

        if (timeout_s) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid_s) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (rx_byte_s)
                    PS2_EXT:   ext_d  = 1'b1;
                    PS2_BRK:   brk_d  = 1'b1;
                    PS2_PAUSE: skip_d = PS2_PAUSE_SKIP;
                    default: begin
                        if (is_ignored(rx_byte_s)) begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                        end else begin
                            key_d.tgl     = ~key_q.tgl;
                            key_d.pressed = ~brk_q;
                            key_d.ext     = ext_q;
                            key_d.code    = rx_byte_s;
                            ext_d         = 1'b0;
                            brk_d         = 1'b0;
                        end
                    end
                endcase
            end
        end else begin
            skip_d = skip_q;
        end
    end

    // Event word, prefix state and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q  <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            key_q  <= key_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
            err_q  <= err_d;
        end
    end

    assign ps2_key = key_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder. The PS/2 bit rate is scaled up relative
// to the system clock (and the timeout shortened) to keep the run short.
module tb_ps2_key_decoder;
    import ps2_pkg::*;

    localparam int FILT  = 8;
    localparam int TOUT  = 1000;
    localparam int HALF  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int evt_cnt = 0;
    logic [10:0] sb[$];
    logic [10:0] prev_key = 11'd0;

    // reference prefix model
    logic       m_tgl = 1'b0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [2:0] m_skip = 3'd0;

    ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .err      (err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Model a correctly received byte; pushes the expected event word if one results.
    task automatic model_byte(input logic [7:0] b);
        if (m_skip != 3'd0) begin
            m_skip = m_skip - 3'd1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 3'd7;
        end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE ||
                     b == 8'h00 || b == 8'hFF) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            sb.push_back({~m_tgl, ~m_brk, m_ext, b});
            m_tgl = ~m_tgl;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Drive the first nbits of an 11-bit frame, device-style (data changes while clk high).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        logic        p;
        p    = ~(^b) ^ bad_par;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic good_byte(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0, 11);
    endtask

    // Monitor: pops the scoreboard on every event-word change, counts err pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (err === 1'b1) err_cnt++;
            if (reset) begin
                prev_key = ps2_key;
            end else if (ps2_key !== prev_key) begin
                evt_cnt++;
                check("err_with_evt", 32'(err), 32'd0);
                if (sb.size() > 0) begin
                    check("sb_key", 32'(ps2_key), 32'(sb.pop_front()));
                end else begin
                    check("sb_spurious", 32'(ps2_key), 32'(prev_key));
                end
                prev_key = ps2_key;
            end
        end
    end

    initial begin
        int e0;
        int r0;
        wait_cyc(4);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(2);
        #1;
        check("rst_key", 32'(ps2_key), 32'h000);
        check("rst_err", 32'(err), 32'd0);

        // 1: single make code
        e0 = evt_cnt; r0 = err_cnt;
        good_byte(8'h1C);
        wait_cyc(50);
        check("t1_key", 32'(ps2_key), 32'h61C);
        check("t1_evts", 32'(evt_cnt - e0), 32'd1);
        check("t1_err", 32'(err_cnt - r0), 32'd0);

        // 2: break code
        e0 = evt_cnt;
        good_byte(8'hF0);
        wait_cyc(50);
        check("t2_no_evt_f0", 32'(evt_cnt - e0), 32'd0);
        good_byte(8'h1C);
        wait_cyc(50);
        check("t2_key", 32'(ps2_key), 32'h01C);
        check("t2_evts", 32'(evt_cnt - e0), 32'd1);

        // 3: extended make then extended break
        good_byte(8'hE0);
        good_byte(8'h75);
        wait_cyc(50);
        check("t3_ext_make", 32'(ps2_key), 32'h775);
        good_byte(8'hE0);
        good_byte(8'hF0);
        good_byte(8'h75);
        wait_cyc(50);
        check("t3_ext_break", 32'(ps2_key), 32'h175);

        // 4: parity error then good frame
        e0 = evt_cnt; r0 = err_cnt;
        send_frame(8'h29, 1'b1, 11);
        wait_cyc(50);
        check("t4_err", 32'(err_cnt - r0), 32'd1);
        check("t4_key_hold", 32'(ps2_key), 32'h175);
        good_byte(8'h29);
        wait_cyc(50);
        check("t4_key", 32'(ps2_key), 32'h629);
        check("t4_evts", 32'(evt_cnt - e0), 32'd1);

        // 5: stalled frame after pending E0 times out and clears the prefix
        good_byte(8'hE0);
        r0 = err_cnt;
        send_frame(8'h5A, 1'b0, 5);
        wait_cyc(TOUT + 2 + 60);
        m_ext = 1'b0;
        m_brk = 1'b0;
        check("t5_err", 32'(err_cnt - r0), 32'd1);
        check("t5_idle", 32'(dut.u_rx.state_q), 32'(ST_IDLE));
        good_byte(8'h5A);
        wait_cyc(50);
        check("t5_key", 32'(ps2_key), 32'h25A);

        // 6: clock glitch, Pause sequence, reset mid-frame
        e0 = evt_cnt; r0 = err_cnt;
        @(negedge clk);
        ps2_clk = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        ps2_clk = 1'b1;
        wait_cyc(50);
        check("t6_glitch_err", 32'(err_cnt - r0), 32'd0);
        check("t6_glitch_state", 32'(dut.u_rx.state_q), 32'(ST_IDLE));
        good_byte(8'hE1); good_byte(8'h14); good_byte(8'h77); good_byte(8'hE1);
        good_byte(8'hF0); good_byte(8'h14); good_byte(8'hF0); good_byte(8'h77);
        wait_cyc(50);
        check("t6_pause_evts", 32'(evt_cnt - e0), 32'd0);
        check("t6_pause_key", 32'(ps2_key), 32'h25A);
        send_frame(8'h1C, 1'b0, 5);
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(2);
        @(negedge clk);
        reset = 1'b0;
        m_tgl = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 3'd0;
        #1;
        check("t6_rst_key", 32'(ps2_key), 32'h000);
        r0 = err_cnt;
        good_byte(8'h1C);
        wait_cyc(50);
        check("t6_post_rst_err", 32'(err_cnt - r0), 32'd0);
        check("t6_post_rst_key", 32'(ps2_key), 32'h61C);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
